guitar_effects_pipeline: RTL and testbench

- Streaming mono guitar-effects datapath: programmable input gain, saturation, then a soft-knee distortion (overdrive) stage.
- Sits between the audio codec receive path and the transmit path.
- Accepts one signed fixed-point sample per valid cycle and returns one processed sample after a fixed pipeline latency.

---
 rtl/guitar_fx_pkg.sv | 32 +++
 rtl/guitar_effects_pipeline_soft_clip.sv | 33 +++
 rtl/guitar_effects_pipeline.sv | 92 +++++++++
 tb/tb_guitar_effects_pipeline.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/guitar_fx_pkg.sv
// Shared configuration and derived constants for the guitar effects pipeline.
package guitar_fx_pkg;

    localparam int unsigned BITS_PER_LEVEL     = 12;
    localparam int unsigned BITS_PER_GAIN_FRAC = 4;
    localparam int unsigned FXP_SIZE           = 16;
    localparam int unsigned GAIN_W             = 11;

    function automatic int unsigned level_shift_of(int unsigned fxp, int unsigned bpl);
        return fxp - 1 - bpl;
    endfunction

    function automatic int knee_of(int unsigned bpl);
        return 2 ** (bpl - 1);
    endfunction

    function automatic int sat_max_of(int unsigned fxp);
        return (2 ** (fxp - 1)) - 1;
    endfunction

    function automatic int sat_min_of(int unsigned fxp);
        return -(2 ** (fxp - 1));
    endfunction

    localparam int unsigned LEVEL_SHIFT = level_shift_of(FXP_SIZE, BITS_PER_LEVEL);
    localparam int          KNEE        = knee_of(BITS_PER_LEVEL);
    localparam int          SAT_MAX     = sat_max_of(FXP_SIZE);
    localparam int          SAT_MIN     = sat_min_of(FXP_SIZE);

    typedef logic signed [FXP_SIZE-1:0] sample_t;

endpackage

// File: rtl/guitar_effects_pipeline_soft_clip.sv
// Soft-knee transfer curve: unity inside +/-Knee, slope 1/4 beyond it.
module soft_clip
    import guitar_fx_pkg::*;
#(
    parameter int unsigned Width = BITS_PER_LEVEL + 1,
    parameter int          Knee  = KNEE
) (
    input  logic signed [Width-1:0] i_level,
    output logic signed [Width-1:0] o_level
);

    localparam int unsigned ExtW = Width + 1;
    localparam logic signed [ExtW-1:0] KneeP = ExtW'(Knee);

    logic signed [ExtW-1:0] w_ext;
    logic signed [ExtW-1:0] w_hi;
    logic signed [ExtW-1:0] w_lo;

    always_comb begin
        w_ext = {i_level[Width-1], i_level};
        // One extra bit keeps v-K / v+K exact before the floor shift.
        w_hi  = KneeP + ((w_ext - KneeP) >>> 2);
        w_lo  = -KneeP + ((w_ext + KneeP) >>> 2);
        if (w_ext > KneeP) begin
            o_level = Width'(w_hi);
        end else if (w_ext < -KneeP) begin
            o_level = Width'(w_lo);
        end else begin
            o_level = i_level;
        end
    end

endmodule

// File: rtl/guitar_effects_pipeline.sv
// Three-stage gain / saturate / soft-knee overdrive datapath, one sample per cycle.
module guitar_effects_pipeline
    import guitar_fx_pkg::*;
#(
    parameter int unsigned BitsPerLevel    = BITS_PER_LEVEL,
    parameter int unsigned BitsPerGainFrac = BITS_PER_GAIN_FRAC,
    parameter int unsigned FxpSize         = FXP_SIZE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [GAIN_W-1:0]         i_par_gain,
    input  logic                      i_valid,
    input  logic signed [FxpSize-1:0] i_sample,
    output logic                      o_valid,
    output logic signed [FxpSize-1:0] o_sample
);

    localparam int unsigned ProdW      = FxpSize + 12;
    localparam int unsigned LevelW     = BitsPerLevel + 1;
    localparam int unsigned LevelShift = level_shift_of(FxpSize, BitsPerLevel);
    localparam logic signed [ProdW-1:0] SatMaxP = ProdW'(sat_max_of(FxpSize));
    localparam logic signed [ProdW-1:0] SatMinP = ProdW'(sat_min_of(FxpSize));

    logic                      r_valid1;
    logic                      r_valid2;
    logic                      r_valid3;
    logic signed [ProdW-1:0]   r_prod;
    logic signed [LevelW-1:0]  r_level;
    logic signed [FxpSize-1:0] r_out;

    logic signed [ProdW-1:0]   w_prod;
    logic signed [ProdW-1:0]   w_shift;
    logic signed [FxpSize-1:0] w_sat;
    logic signed [FxpSize-1:0] w_sat_shift;
    logic signed [LevelW-1:0]  w_level;
    logic signed [LevelW-1:0]  w_clip;
    logic signed [FxpSize-1:0] w_out;

    // Gain is zero-extended so the multiply stays signed without a sign flip.
    assign w_prod = ProdW'(i_sample) * ProdW'($signed({1'b0, i_par_gain}));

    always_comb begin
        w_shift = r_prod >>> BitsPerGainFrac;
        if (w_shift > SatMaxP) begin
            w_sat = FxpSize'(SatMaxP);
        end else if (w_shift < SatMinP) begin
            w_sat = FxpSize'(SatMinP);
        end else begin
            w_sat = FxpSize'(w_shift);
        end
        w_sat_shift = w_sat >>> LevelShift;
        w_level     = LevelW'(w_sat_shift);
    end

    soft_clip #(
        .Width (LevelW),
        .Knee  (knee_of(BitsPerLevel))
    ) u_soft_clip (
        .i_level (r_level),
        .o_level (w_clip)
    );

    assign w_out = FxpSize'(w_clip) <<< LevelShift;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid1 <= 1'b0;
            r_valid2 <= 1'b0;
            r_valid3 <= 1'b0;
            r_prod   <= '0;
            r_level  <= '0;
            r_out    <= '0;
        end else begin
            r_valid1 <= i_valid;
            r_valid2 <= r_valid1;
            r_valid3 <= r_valid2;
            if (i_valid) begin
                r_prod <= w_prod;
            end
            if (r_valid1) begin
                r_level <= w_level;
            end
            if (r_valid2) begin
                r_out <= w_out;
            end
        end
    end

    assign o_valid  = r_valid3;
    assign o_sample = r_out;

endmodule

// File: tb/tb_guitar_effects_pipeline.sv
// Self-checking bench: directed scenarios plus random stream against an arithmetic model.
module tb_guitar_effects_pipeline;

    logic               clk;
    logic               rst;
    logic [10:0]        i_par_gain;
    logic               i_valid;
    logic signed [15:0] i_sample;
    logic               o_valid;
    logic signed [15:0] o_sample;

    int n_checks;
    int n_errors;

    // Expected output delay line (entries pushed per driven cycle) and held output.
    logic               exp_q_v[$];
    int                 exp_q_d[$];
    logic               exp_valid;
    logic signed [15:0] exp_sample;

    guitar_effects_pipeline u_dut (
        .clk        (clk),
        .rst        (rst),
        .i_par_gain (i_par_gain),
        .i_valid    (i_valid),
        .i_sample   (i_sample),
        .o_valid    (o_valid),
        .o_sample   (o_sample)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint floor_div(input longint a, input longint b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    // Reference: scale by gain/16, clamp to 16-bit, quantise to 1/8, soft knee at 2048.
    function automatic int ref_fx(input int s, input int gain);
        longint g;
        longint v;
        longint y;
        g = floor_div(longint'(s) * longint'(gain), 16);
        if (g > 32767) g = 32767;
        if (g < -32768) g = -32768;
        v = floor_div(g, 8);
        if (v > 2048) y = 2048 + floor_div(v - 2048, 4);
        else if (v < -2048) y = -2048 + floor_div(v + 2048, 4);
        else y = v;
        return int'(y * 8);
    endfunction

    task automatic model_reset();
        exp_q_v.delete();
        exp_q_d.delete();
        exp_q_v.push_back(1'b0);
        exp_q_v.push_back(1'b0);
        exp_q_d.push_back(0);
        exp_q_d.push_back(0);
        exp_valid  = 1'b0;
        exp_sample = 16'sd0;
    endtask

    task automatic step(input logic v, input int gain, input int s);
        logic fv;
        int   fd;
        i_valid    = v;
        i_par_gain = 11'(gain);
        i_sample   = 16'(s);
        @(posedge clk);
        exp_q_v.push_back(v);
        exp_q_d.push_back(ref_fx(s, gain));
        fv = exp_q_v.pop_front();
        fd = exp_q_d.pop_front();
        exp_valid = fv;
        if (fv) exp_sample = 16'(fd);
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        i_valid    = 1'b1;
        i_par_gain = 11'd16;
        i_sample   = 16'sd1234;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (o_valid !== 1'b0 || o_sample !== 16'sd0) begin
            n_errors++;
            $display("FAIL reset_state got valid=%0b sample=%0d expected valid=0 sample=0",
                     o_valid, o_sample);
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16, 0);
            n_checks++;
            if (o_valid !== 1'b0 || o_sample !== 16'sd0) begin
                n_errors++;
                $display("FAIL reset_ignored_valid got valid=%0b sample=%0d expected 0/0",
                         o_valid, o_sample);
            end
        end
    endtask

    task automatic test_unity();
        for (int i = 0; i < 4; i++) begin
            step(i == 0, 16, (i == 0) ? 1000 : 0);
            n_checks++;
            if (o_valid !== (i == 2)) begin
                n_errors++;
                $display("FAIL unity_latency step=%0d got valid=%0b expected %0b",
                         i, o_valid, (i == 2));
            end
            if (i == 2) begin
                n_checks++;
                if (o_sample !== 16'sd1000) begin
                    n_errors++;
                    $display("FAIL unity_value got %0d expected 1000", o_sample);
                end
            end
        end
    endtask

    task automatic test_knee_and_saturation();
        int tbl[8][3] = '{
            '{16, 20000, 17288}, '{16, -20000, -17288}, '{1600, 1000, 20472},
            '{1600, -1000, -20480}, '{2047, -32768, -20480}, '{2047, 32767, 20472},
            '{0, 12345, 0}, '{32, 8000, 16000}
        };
        for (int t = 0; t < 8; t++) begin
            step(1'b1, tbl[t][0], tbl[t][1]);
            step(1'b0, 0, 0);
            step(1'b0, 0, 0);
            n_checks++;
            if (o_valid !== 1'b1 || o_sample !== 16'(tbl[t][2])) begin
                n_errors++;
                $display("FAIL knee_sat gain=%0d in=%0d got valid=%0b sample=%0d expected 1/%0d",
                         tbl[t][0], tbl[t][1], o_valid, o_sample, tbl[t][2]);
            end
        end
    endtask

    task automatic test_gaps();
        logic pat[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            step(pat[i], (i == 0) ? 0 : int'($urandom_range(1, 200)),
                 int'($urandom_range(0, 65535)) - 32768);
            n_checks++;
            if (o_valid !== exp_valid || o_sample !== exp_sample) begin
                n_errors++;
                $display("FAIL gaps step=%0d got valid=%0b sample=%0d expected %0b/%0d",
                         i, o_valid, o_sample, exp_valid, exp_sample);
            end
        end
    endtask

    task automatic test_back_to_back();
        int s;
        for (int i = 0; i < 66; i++) begin
            s = $rtoi($floor(8000.0 * $sin(2.0 * 3.14159265358979 * i / 32.0) + 0.5));
            step(i < 64, (i < 32) ? 16 : 32, s);
            n_checks++;
            if (o_valid !== exp_valid || o_sample !== exp_sample) begin
                n_errors++;
                $display("FAIL back_to_back step=%0d got valid=%0b sample=%0d expected %0b/%0d",
                         i, o_valid, o_sample, exp_valid, exp_sample);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 16, 3000);
        step(1'b1, 16, -3000);
        rst     = 1'b1;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        n_checks++;
        if (o_valid !== 1'b0 || o_sample !== 16'sd0) begin
            n_errors++;
            $display("FAIL reset_mid got valid=%0b sample=%0d expected 0/0", o_valid, o_sample);
        end
        for (int i = 0; i < 6; i++) begin
            step(i == 2, 16, 1000);
            n_checks++;
            if (o_valid !== (i == 4) || o_sample !== ((i >= 4) ? 16'sd1000 : 16'sd0)) begin
                n_errors++;
                $display("FAIL reset_resume step=%0d got valid=%0b sample=%0d", i, o_valid,
                         o_sample);
            end
        end
    endtask

    task automatic test_random();
        int gain;
        int s;
        for (int i = 0; i < 400; i++) begin
            gain = ($urandom_range(0, 7) == 0) ? 2047 : int'($urandom_range(0, 2047));
            s    = ($urandom_range(0, 9) == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
            step($urandom_range(0, 3) != 0, gain, s);
            n_checks++;
            if (o_valid !== exp_valid || o_sample !== exp_sample) begin
                n_errors++;
                $display("FAIL random step=%0d got valid=%0b sample=%0d expected %0b/%0d",
                         i, o_valid, o_sample, exp_valid, exp_sample);
            end
        end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        i_valid    = 1'b0;
        i_par_gain = '0;
        i_sample   = '0;
        model_reset();
        test_reset();
        test_unity();
        test_knee_and_saturation();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
